// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter of NUM_REQ byte requesters onto a single Tx FIFO write port.
// Grant is registered one cycle after a request; data bytes pass through with zero latency; full stalls everything.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int HEADER_EN = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 write,
    output logic [7:0]           wdata,
    input  logic                 full,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_pulse
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] STALL_LIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [OW-1:0] LAST_INIT = OW'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_XFER} state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [OW-1:0]      r_owner;
    logic [OW-1:0]      r_last_owner;
    logic [TW-1:0]      r_stall;
    logic               r_timeout;

    logic               w_any;
    logic [OW-1:0]      w_sel;
    logic [OW-1:0]      w_idx;
    logic               w_own_vld;
    logic               w_own_last;
    logic [7:0]         w_own_byte;
    logic               w_hdr_wr;
    logic               w_hs;

    // Search starts just past the previous owner so every requester gets a fair turn.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (int'(r_last_owner) + k >= NUM_REQ)
                w_idx = OW'(int'(r_last_owner) + k - NUM_REQ);
            else
                w_idx = OW'(int'(r_last_owner) + k);
            if (!w_any && req_valid[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    always_comb begin
        w_own_vld  = 1'b0;
        w_own_last = 1'b0;
        w_own_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_own_vld  = req_valid[i];
                w_own_last = req_last[i];
                w_own_byte = req_data[8*i +: 8];
            end
        end
    end

    assign w_hdr_wr  = (r_state == S_HDR) && !full;
    assign w_hs      = (r_state == S_XFER) && w_own_vld && !full;
    assign req_ready = ((r_state == S_XFER) && !full) ? r_grant : '0;
    assign write     = w_hdr_wr || w_hs;
    assign grant     = r_grant;
    assign busy      = |r_grant;
    assign timeout_pulse = r_timeout;

    always_comb begin
        wdata = 8'h00;
        if (w_hdr_wr)
            wdata = 8'h30 + {{(8-OW){1'b0}}, r_owner};
        else if (w_hs)
            wdata = w_own_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= LAST_INIT;
            r_stall      <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_sel;
                        r_grant <= NUM_REQ'(1) << w_sel;
                        r_stall <= '0;
                        r_state <= (HEADER_EN != 0) ? S_HDR : S_XFER;
                    end
                end
                S_HDR: begin
                    if (!full) begin
                        r_stall <= '0;
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_hs) begin
                        r_stall <= '0;
                        if (w_own_last) begin
                            r_grant      <= '0;
                            r_last_owner <= r_owner;
                            r_state      <= S_IDLE;
                        end
                    end else if (!w_own_vld && TIMEOUT > 0) begin
                        // Only a silent owner ages the timer; a blocked FIFO does not.
                        if (r_stall == STALL_LIM) begin
                            r_timeout    <= 1'b1;
                            r_grant      <= '0;
                            r_last_owner <= r_owner;
                            r_stall      <= '0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_stall <= r_stall + TW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle vector table, hand-written corner sequences and a
// randomized packet stream scored against a packet-level round-robin model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [8*N-1:0] req_data = '0;
    logic           full = 1'b0;
    logic [N-1:0]   req_ready, grant;
    logic           write, busy, timeout_pulse;
    logic [7:0]     wdata;

    logic [N-1:0]   b_valid = '0;
    logic [N-1:0]   b_last = '0;
    logic [8*N-1:0] b_data = '0;
    logic           b_full = 1'b0;
    logic [N-1:0]   b_ready, b_grant;
    logic           b_write, b_busy, b_to;
    logic [7:0]     b_wdata;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .HEADER_EN(1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .write(write), .wdata(wdata), .full(full), .grant(grant),
        .busy(busy), .timeout_pulse(timeout_pulse)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .HEADER_EN(0), .TIMEOUT(0)) dut_nh (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data), .req_last(b_last),
        .req_ready(b_ready), .write(b_write), .wdata(b_wdata), .full(b_full), .grant(b_grant),
        .busy(b_busy), .timeout_pulse(b_to)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic apply(input logic [N-1:0] v, input logic [8*N-1:0] d, input logic [N-1:0] l, input logic f);
        @(negedge clk);
        req_valid = v; req_data = d; req_last = l; full = f;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; full = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]   v;
        logic [8*N-1:0] d;
        logic [N-1:0]   l;
        logic           f;
        logic           w;
        logic [7:0]     wd;
        logic [N-1:0]   g;
        logic [N-1:0]   rdy;
    } vec_t;
    vec_t tbl[16];

    // Packet-level scoreboard state shared by the stream tasks.
    logic [7:0] src_d [N][$];
    bit         src_l [N][$];
    logic [7:0] exp_d [N][$];
    bit         exp_l [N][$];
    int         gap   [N];
    logic [7:0] tag_log [$];

    task automatic add_pkt(input int r, input int len);
        for (int k = 0; k < len; k++) begin
            logic [7:0] b;
            b = 8'($urandom);
            src_d[r].push_back(b); src_l[r].push_back(k == len - 1);
            exp_d[r].push_back(b); exp_l[r].push_back(k == len - 1);
        end
    endtask

    function automatic int rr_pick(input int last);
        for (int k = 1; k <= N; k++) begin
            int r;
            r = (last + k) % N;
            if (exp_d[r].size() > 0) return r;
        end
        return -1;
    endfunction

    function automatic int pending();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += src_d[i].size() + exp_d[i].size();
        return s;
    endfunction

    // Non-owners present their first byte continuously, so at arbitration time a
    // requester is valid exactly when it still has bytes queued.
    task automatic run_stream(input int max_cyc, input int full_pct, input int max_gap);
        int  m_owner;
        int  m_last;
        bit  hs [N];
        bit  any_hs;
        m_owner = -1;
        m_last  = N - 1;
        for (int i = 0; i < N; i++) gap[i] = 0;
        for (int c = 0; c < max_cyc; c++) begin
            if (pending() == 0) break;
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                req_valid[i]       = (src_d[i].size() > 0) && (gap[i] == 0);
                req_data[8*i +: 8] = (src_d[i].size() > 0) ? src_d[i][0] : 8'h00;
                req_last[i]        = (src_d[i].size() > 0) ? src_l[i][0] : 1'b0;
            end
            full = ($urandom_range(99) < full_pct);
            #1;
            any_hs = 1'b0;
            for (int i = 0; i < N; i++) begin
                hs[i]  = req_valid[i] && req_ready[i];
                any_hs = any_hs | hs[i];
            end
            chk("write while full", 32'(write & full), 32'd0);
            chk("busy vs grant", 32'(busy), 32'(|grant));
            chk("grant one-hot", 32'($countones(grant) <= 1), 32'd1);
            chk("ready outside owner", 32'(req_ready & ~grant), 32'd0);
            chk("spurious timeout", 32'(timeout_pulse), 32'd0);
            if (m_owner >= 0) begin
                chk("owner held mid-packet", 32'(grant), 32'd1 << m_owner);
                chk("write iff handshake", 32'(write), 32'(any_hs));
            end
            if (write) begin
                if (m_owner < 0) begin
                    m_owner = rr_pick(m_last);
                    chk("write with a packet pending", 32'(m_owner >= 0), 32'd1);
                    if (m_owner >= 0) begin
                        chk("header tag", 32'(wdata), 32'(8'h30 + m_owner));
                        tag_log.push_back(wdata);
                    end
                end else if (exp_d[m_owner].size() > 0) begin
                    chk("payload byte", 32'(wdata), 32'(exp_d[m_owner].pop_front()));
                    if (exp_l[m_owner].pop_front()) begin
                        m_last  = m_owner;
                        m_owner = -1;
                    end
                end
            end
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                if (gap[i] > 0) gap[i]--;
                else if (hs[i]) begin
                    bit lb;
                    lb = src_l[i].pop_front();
                    void'(src_d[i].pop_front());
                    if (!lb) gap[i] = $urandom_range(max_gap);
                end
            end
        end
        chk("stream drained", 32'(pending()), 32'd0);
        @(negedge clk);
        req_valid = '0; req_last = '0; req_data = '0; full = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected under 1000000", $time);
        $fatal(1);
    end

    initial begin
        int nw;

        // Single packet A1..A3 from requester 2, then B1,B2 from requester 1 with a 5-cycle full stall.
        tbl[0]  = '{4'b0100, 32'h00A1_0000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0100, 32'h00A1_0000, 4'b0000, 1'b0, 1'b1, 8'h32, 4'b0100, 4'b0000};
        tbl[2]  = '{4'b0100, 32'h00A1_0000, 4'b0000, 1'b0, 1'b1, 8'hA1, 4'b0100, 4'b0100};
        tbl[3]  = '{4'b0100, 32'h00A2_0000, 4'b0000, 1'b0, 1'b1, 8'hA2, 4'b0100, 4'b0100};
        tbl[4]  = '{4'b0100, 32'h00A3_0000, 4'b0100, 1'b0, 1'b1, 8'hA3, 4'b0100, 4'b0100};
        tbl[5]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b0010, 32'h0000_B100, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0010, 32'h0000_B100, 4'b0000, 1'b0, 1'b1, 8'h31, 4'b0010, 4'b0000};
        tbl[8]  = '{4'b0010, 32'h0000_B100, 4'b0000, 1'b0, 1'b1, 8'hB1, 4'b0010, 4'b0010};
        for (int r = 9; r < 14; r++)
            tbl[r] = '{4'b0010, 32'h0000_B200, 4'b0010, 1'b1, 1'b0, 8'h00, 4'b0010, 4'b0000};
        tbl[14] = '{4'b0010, 32'h0000_B200, 4'b0010, 1'b0, 1'b1, 8'hB2, 4'b0010, 4'b0010};
        tbl[15] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000};

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset write", 32'(write), 32'd0);
        chk("reset wdata", 32'(wdata), 32'd0);
        chk("reset timeout_pulse", 32'(timeout_pulse), 32'd0);
        chk("reset grant (no header)", 32'(b_grant), 32'd0);
        rst = 1'b0;

        for (int r = 0; r < 16; r++) begin
            apply(tbl[r].v, tbl[r].d, tbl[r].l, tbl[r].f);
            chk($sformatf("vec%0d write", r), 32'(write), 32'(tbl[r].w));
            chk($sformatf("vec%0d wdata", r), 32'(wdata), 32'(tbl[r].wd));
            chk($sformatf("vec%0d grant", r), 32'(grant), 32'(tbl[r].g));
            chk($sformatf("vec%0d req_ready", r), 32'(req_ready), 32'(tbl[r].rdy));
            chk($sformatf("vec%0d busy", r), 32'(busy), 32'(|tbl[r].g));
            chk($sformatf("vec%0d timeout_pulse", r), 32'(timeout_pulse), 32'd0);
        end

        // All four requesters hold a 2-byte packet from reset.
        do_reset();
        tag_log.delete();
        for (int i = 0; i < N; i++) add_pkt(i, 2);
        run_stream(200, 0, 0);
        chk("contention packet count", 32'(tag_log.size()), 32'd4);
        for (int i = 0; i < N && i < tag_log.size(); i++)
            chk($sformatf("contention tag %0d", i), 32'(tag_log[i]), 32'(8'h30 + i));

        // Randomized packets with FIFO backpressure and short owner gaps.
        do_reset();
        tag_log.delete();
        for (int i = 0; i < N; i++) begin
            int npk;
            npk = $urandom_range(3, 6);
            for (int p = 0; p < npk; p++) add_pkt(i, $urandom_range(1, 6));
        end
        run_stream(5000, 30, 2);

        // Timeout: requester 0 goes silent after its first byte while requester 1 waits.
        do_reset();
        apply(4'b0011, 32'h0000_2010, 4'b0000, 1'b0);
        chk("to: idle grant", 32'(grant), 32'd0);
        apply(4'b0011, 32'h0000_2010, 4'b0000, 1'b0);
        chk("to: header tag", 32'(wdata), 32'h30);
        apply(4'b0011, 32'h0000_2010, 4'b0000, 1'b0);
        chk("to: byte1 write", 32'(write), 32'd1);
        chk("to: byte1 data", 32'(wdata), 32'h10);
        for (int c = 0; c < TO; c++) begin
            apply(4'b0010, 32'h0000_2000, 4'b0000, 1'b0);
            chk($sformatf("to: stall%0d pulse", c), 32'(timeout_pulse), 32'd0);
            chk($sformatf("to: stall%0d grant", c), 32'(grant), 32'b0001);
            chk($sformatf("to: stall%0d write", c), 32'(write), 32'd0);
        end
        // The pulse lands TO cycles after the first silent cycle.
        apply(4'b0010, 32'h0000_2000, 4'b0000, 1'b0);
        chk("to: pulse", 32'(timeout_pulse), 32'd1);
        chk("to: grant cleared", 32'(grant), 32'd0);
        chk("to: no tail write", 32'(write), 32'd0);
        apply(4'b0010, 32'h0000_2000, 4'b0000, 1'b0);
        chk("to: pulse one cycle", 32'(timeout_pulse), 32'd0);
        chk("to: next owner", 32'(grant), 32'b0010);
        chk("to: next tag", 32'(wdata), 32'h31);

        // Reset after byte 2 of requester 1's packet; last owner is 0 at this point.
        apply(4'b0010, 32'h0000_2100, 4'b0000, 1'b0);
        chk("rst: byte1", 32'(wdata), 32'h21);
        apply(4'b0111, 32'h0000_2200, 4'b0000, 1'b0);
        chk("rst: byte2", 32'(wdata), 32'h22);
        apply(4'b0111, 32'h0000_2300, 4'b0000, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst: write dropped", 32'(write), 32'd0);
        chk("rst: grant dropped", 32'(grant), 32'd0);
        chk("rst: busy dropped", 32'(busy), 32'd0);
        chk("rst: ready dropped", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst: idle after release", 32'(grant), 32'd0);
        apply(4'b0111, 32'h0000_2300, 4'b0000, 1'b0);
        chk("rst: requester 0 wins", 32'(grant), 32'b0001);
        chk("rst: requester 0 tag", 32'(wdata), 32'h30);
        apply(4'b0000, 32'h0, 4'b0000, 1'b0);

        // No-header instance: one single-byte packet on requester 1.
        nw = 0;
        @(negedge clk);
        b_valid = 4'b0010; b_data = 32'h0000_5C00; b_last = 4'b0010;
        #1;
        nw += int'(b_write);
        chk("nh: idle grant", 32'(b_grant), 32'd0);
        @(negedge clk);
        #1;
        nw += int'(b_write);
        chk("nh: write", 32'(b_write), 32'd1);
        chk("nh: wdata", 32'(b_wdata), 32'h5C);
        chk("nh: ready", 32'(b_ready), 32'b0010);
        @(negedge clk);
        b_valid = '0; b_last = '0; b_data = '0;
        #1;
        nw += int'(b_write);
        chk("nh: back to idle", 32'(b_grant), 32'd0);
        chk("nh: busy low", 32'(b_busy), 32'd0);
        @(negedge clk);
        #1;
        nw += int'(b_write);
        chk("nh: write count", 32'(nw), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter HEADER_EN, default 1, which, when 1, prefixes each packet with a channel tag byte.
REQ-003 SHALL have parameter TIMEOUT, default 255, which sets the mid-packet stall limit in cycles; 0 disables the timeout.
REQ-004 SHALL have port clk  input  1  sole clock.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester byte valid.
REQ-007 SHALL have port req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 SHALL have port req_last  input  NUM_REQ  marks the final byte of a packet.
REQ-009 SHALL have port req_ready  output  NUM_REQ  per-requester byte accept.
REQ-010 SHALL have port write  output  1  Tx FIFO write strobe.
REQ-011 SHALL have port wdata  output  8  Tx FIFO write data.
REQ-012 SHALL have port full  input  1  Tx FIFO full.
REQ-013 SHALL have port grant  output  NUM_REQ  one-hot current owner; all zero when idle.
REQ-014 SHALL have port busy  output  1  high whenever grant is non-zero.
REQ-015 SHALL have port timeout_pulse  output  1  one-cycle pulse on a timeout abort.

Function
REQ-016 SHALL implement states IDLE, HDR and XFER.
REQ-017 In IDLE, when any req_valid bit is high, SHALL select a requester round-robin, searching from (last_owner+1) mod NUM_REQ upward; grant SHALL be registered and visible on the next cycle.
REQ-018 From IDLE, SHALL go to HDR if HEADER_EN=1, else to XFER.
REQ-019 In HDR, when full=0, SHALL assert write=1 for one cycle with wdata=8'h30+owner index, then go to XFER; while full=1, SHALL hold in HDR with write=0.
REQ-020 In XFER, req_ready[i] SHALL be combinationally equal to grant[i] AND NOT full; all other req_ready bits SHALL be 0.
REQ-021 In XFER, a handshake (req_valid & req_ready of the owner) SHALL set write=1 and wdata=owner byte in the same cycle, giving zero latency.
REQ-022 A handshake with req_last=1 SHALL end the packet: grant clears next cycle, last_owner updates to the owner, and the state returns to IDLE.
REQ-023 write SHALL never be 1 while full=1.
REQ-024 Exactly one byte SHALL be written per write cycle, and no byte SHALL be dropped or duplicated.
REQ-025 The stall timer SHALL count XFER cycles in which the owner req_valid=0, and SHALL clear on every handshake and on entry to XFER.
REQ-026 Cycles with req_valid=1 and full=1 SHALL NOT advance the stall timer.
REQ-027 When the stall timer reaches TIMEOUT (TIMEOUT>0), SHALL pulse timeout_pulse for one cycle, update last_owner, clear grant and return to IDLE; no tail byte is emitted.
REQ-028 A packet of a single byte (valid and last together) SHALL be legal.
REQ-029 When several requesters request at once, only the round-robin winner is granted; the others SHALL see req_ready=0 until they win.
REQ-030 A requester deasserting req_valid while not granted SHALL have no effect.
REQ-031 Grant SHALL not change mid-packet except on timeout or reset.
REQ-032 busy SHALL equal the OR of the grant bits.

Reset
REQ-033 On rst=1, SHALL asynchronously force: state IDLE, grant=0, busy=0, req_ready=0, write=0, wdata=8'h00, timeout_pulse=0, stall timer=0, last_owner=NUM_REQ-1 so that requester 0 has first priority.
REQ-034 Reset asserted mid-packet SHALL abandon the packet with no further write; after release, arbitration restarts from requester 0.

Verification
REQ-035 Single packet: requester 2 sends 3 bytes A1,A2,A3 (last on A3) with HEADER_EN=1 and full=0 -> the FIFO receives 32,A1,A2,A3 on consecutive cycles, then grant=0.
REQ-036 Contention: all 4 requesters hold 2-byte packets from reset -> packets emerge with tags 30,31,32,33 in that order, never interleaved.
REQ-037 Backpressure: full=1 for 5 cycles during XFER -> write=0 and req_ready=0 throughout, no timeout, and the stream resumes intact.
REQ-038 Timeout with TIMEOUT=4: the owner drops req_valid after byte 1 -> timeout_pulse occurs exactly 4 cycles later, grant clears, and the next requester is served.
REQ-039 Reset mid-packet: rst asserted after byte 2 of 5 -> write=0 and grant=0 immediately; after release, requester 0 wins if it requests.
REQ-040 HEADER_EN=0 with a 1-byte packet on requester 1 -> exactly one write of that byte, and the state returns to IDLE on the next cycle.
